// File: rtl/sprite_collision_unit_if.sv
// Pixel-stream and collision-result bundle for sprite_collision_unit.
// hit_x/hit_y exist only when SPRITE_COLLISION_COORD_EN is defined.
interface sprite_collision_unit_if #(
    parameter int unsigned HIT_W = 8
);
    logic             display_on;
    logic             vsync;
    logic [9:0]       hpos;
    logic [9:0]       vpos;
    logic             gfx_a;
    logic             gfx_b;
    logic             playfield;
    logic             coll_a_pf;
    logic             coll_b_pf;
    logic             coll_ab;
    logic             frame_done;
    logic             hit_pulse;
    logic [HIT_W-1:0] hit_count;
    logic             cooldown_active;
`ifdef SPRITE_COLLISION_COORD_EN
    logic [9:0]       hit_x;
    logic [9:0]       hit_y;
`endif

    modport master (
        output display_on, vsync, hpos, vpos, gfx_a, gfx_b, playfield,
`ifdef SPRITE_COLLISION_COORD_EN
        input  hit_x, hit_y,
`endif
        input  coll_a_pf, coll_b_pf, coll_ab, frame_done, hit_pulse, hit_count, cooldown_active
    );

    modport slave (
        input  display_on, vsync, hpos, vpos, gfx_a, gfx_b, playfield,
`ifdef SPRITE_COLLISION_COORD_EN
        output hit_x, hit_y,
`endif
        output coll_a_pf, coll_b_pf, coll_ab, frame_done, hit_pulse, hit_count, cooldown_active
    );
endinterface

// File: rtl/sprite_collision_unit.sv
// Per-frame tank/playfield collision flags with a cooldown-gated saturating A-vs-B hit counter.
// Define SPRITE_COLLISION_COORD_EN to also publish the first A-B overlap position (hit_x/hit_y).
module sprite_collision_unit #(
    parameter int unsigned HIT_W           = 8,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input logic                    clk,
    input logic                    reset,
    sprite_collision_unit_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StCooldown} state_e;

    localparam logic [7:0]       CdnLoad  = 8'(COOLDOWN_FRAMES);
    localparam logic [HIT_W-1:0] CountMax = '1;

    state_e           state_q;
    logic [7:0]       cdn_q;
    logic             vsync_q;
    logic             vsync_low_seen_q;
    logic             acc_a_pf_q, acc_b_pf_q, acc_ab_q;
    logic             coll_a_pf_q, coll_b_pf_q, coll_ab_q;
    logic             frame_done_q, hit_pulse_q;
    logic [HIT_W-1:0] hit_count_q;

    logic hit_a_pf, hit_b_pf, hit_ab, ab_now, fe;

    assign hit_a_pf = bus.display_on & bus.gfx_a & bus.playfield;
    assign hit_b_pf = bus.display_on & bus.gfx_b & bus.playfield;
    assign hit_ab   = bus.display_on & bus.gfx_a & bus.gfx_b;
    assign ab_now   = acc_ab_q | hit_ab;
    // A vsync already high when reset drops must be seen low once before it can close a frame.
    assign fe       = bus.vsync & ~vsync_q & vsync_low_seen_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            cdn_q            <= 8'd0;
            vsync_q          <= 1'b0;
            vsync_low_seen_q <= 1'b0;
            acc_a_pf_q       <= 1'b0;
            acc_b_pf_q       <= 1'b0;
            acc_ab_q         <= 1'b0;
            coll_a_pf_q      <= 1'b0;
            coll_b_pf_q      <= 1'b0;
            coll_ab_q        <= 1'b0;
            frame_done_q     <= 1'b0;
            hit_pulse_q      <= 1'b0;
            hit_count_q      <= '0;
        end else begin
            vsync_q      <= bus.vsync;
            frame_done_q <= fe;
            hit_pulse_q  <= 1'b0;
            if (!bus.vsync) begin
                vsync_low_seen_q <= 1'b1;
            end
            if (fe) begin
                coll_a_pf_q <= acc_a_pf_q | hit_a_pf;
                coll_b_pf_q <= acc_b_pf_q | hit_b_pf;
                coll_ab_q   <= ab_now;
                acc_a_pf_q  <= 1'b0;
                acc_b_pf_q  <= 1'b0;
                acc_ab_q    <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (ab_now) begin
                            state_q     <= StCooldown;
                            hit_pulse_q <= 1'b1;
                            cdn_q       <= CdnLoad;
                            if (hit_count_q != CountMax) begin
                                hit_count_q <= hit_count_q + HIT_W'(1);
                            end
                        end
                    end
                    StCooldown: begin
                        cdn_q <= cdn_q - 8'd1;
                        if (cdn_q < 8'd2) begin
                            state_q <= StIdle;
                        end
                    end
                endcase
            end else begin
                acc_a_pf_q <= acc_a_pf_q | hit_a_pf;
                acc_b_pf_q <= acc_b_pf_q | hit_b_pf;
                acc_ab_q   <= acc_ab_q | hit_ab;
            end
        end
    end

    assign bus.coll_a_pf       = coll_a_pf_q;
    assign bus.coll_b_pf       = coll_b_pf_q;
    assign bus.coll_ab         = coll_ab_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.hit_pulse       = hit_pulse_q;
    assign bus.hit_count       = hit_count_q;
    assign bus.cooldown_active = (state_q == StCooldown);

`ifdef SPRITE_COLLISION_COORD_EN
    logic [9:0] cap_x_q, cap_y_q, hit_x_q, hit_y_q;

    // cap_* hold the first overlap of the open frame; an overlap on the fe cycle itself
    // is only first when nothing was captured earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_x_q <= 10'd0;
            cap_y_q <= 10'd0;
            hit_x_q <= 10'd0;
            hit_y_q <= 10'd0;
        end else if (fe) begin
            if (ab_now) begin
                hit_x_q <= acc_ab_q ? cap_x_q : bus.hpos;
                hit_y_q <= acc_ab_q ? cap_y_q : bus.vpos;
            end
        end else if (hit_ab && !acc_ab_q) begin
            cap_x_q <= bus.hpos;
            cap_y_q <= bus.vpos;
        end
    end

    assign bus.hit_x = hit_x_q;
    assign bus.hit_y = hit_y_q;
`else
    logic unused_pos;
    assign unused_pos = ^{bus.hpos, bus.vpos};
`endif
endmodule

// File: tb/tb_sprite_collision_unit.sv
// Frame-level bench for sprite_collision_unit: table of frames, expectations queued at each
// vsync rise and checked when frame_done appears; plus a mid-frame reset sequence.
module tb_sprite_collision_unit;
    localparam int unsigned HIT_W = 2;
    localparam int unsigned CDF   = 2;

    logic clk;
    logic reset;

    sprite_collision_unit_if #(.HIT_W(HIT_W)) bus ();

    sprite_collision_unit #(
        .HIT_W          (HIT_W),
        .COOLDOWN_FRAMES(CDF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit a_pf, fe_apf, b_pf, masked, all3, ab, fe_ab;
        bit e_apf, e_bpf, e_ab, e_hp;
        int e_cnt;
        bit e_cd;
        int e_x, e_y;
    } vec_t;

    typedef struct {
        int idx;
        int apf, bpf, ab, hp, cnt, cd, x, y;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drive(input bit dis, input bit ga, input bit gb, input bit pf,
                         input int x, input int y, input bit vs);
        @(posedge clk);
        #1;
        bus.display_on = dis;
        bus.gfx_a      = ga;
        bus.gfx_b      = gb;
        bus.playfield  = pf;
        bus.hpos       = 10'(x);
        bus.vpos       = 10'(y);
        bus.vsync      = vs;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        exp_t e;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, v.a_pf, 0, v.a_pf, 100, 50, 0);
        drive(1, 1, 0, 0, 301, 45, 0);
        drive(1, 0, v.b_pf, v.b_pf, 110, 50, 0);
        drive(1, v.all3, v.all3, v.all3, 90, 20, 0);
        drive(1, v.ab, v.ab, 0, 120, 40, 0);
        drive(0, v.masked, v.masked, v.masked, 305, 45, 0);
        drive(1, 0, 1, 0, 306, 50, 0);
        drive(1, v.ab, v.ab, 0, 130, 60, 0);
        // vsync rises here; this pixel belongs to the frame being closed
        drive(v.fe_apf | v.fe_ab, v.fe_apf | v.fe_ab, v.fe_ab, v.fe_apf, 200, 70, 1);
        e = '{idx: idx, apf: v.e_apf, bpf: v.e_bpf, ab: v.e_ab, hp: v.e_hp, cnt: v.e_cnt,
              cd: v.e_cd, x: v.e_x, y: v.e_y};
        q.push_back(e);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        chk($sformatf("f%0d frame_done seen (pending)", idx), q.size(), 0);
        q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " coll_a_pf"}, int'(bus.coll_a_pf), 0);
        chk({tag, " coll_b_pf"}, int'(bus.coll_b_pf), 0);
        chk({tag, " coll_ab"}, int'(bus.coll_ab), 0);
        chk({tag, " frame_done"}, int'(bus.frame_done), 0);
        chk({tag, " hit_pulse"}, int'(bus.hit_pulse), 0);
        chk({tag, " hit_count"}, int'(bus.hit_count), 0);
        chk({tag, " cooldown_active"}, int'(bus.cooldown_active), 0);
`ifdef SPRITE_COLLISION_COORD_EN
        chk({tag, " hit_x"}, int'(bus.hit_x), 0);
        chk({tag, " hit_y"}, int'(bus.hit_y), 0);
`endif
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (bus.frame_done) begin
                if (q.size() == 0) begin
                    chk("unexpected frame_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("f%0d coll_a_pf", e.idx), int'(bus.coll_a_pf), e.apf);
                    chk($sformatf("f%0d coll_b_pf", e.idx), int'(bus.coll_b_pf), e.bpf);
                    chk($sformatf("f%0d coll_ab", e.idx), int'(bus.coll_ab), e.ab);
                    chk($sformatf("f%0d hit_pulse", e.idx), int'(bus.hit_pulse), e.hp);
                    chk($sformatf("f%0d hit_count", e.idx), int'(bus.hit_count), e.cnt);
                    chk($sformatf("f%0d cooldown_active", e.idx), int'(bus.cooldown_active), e.cd);
`ifdef SPRITE_COLLISION_COORD_EN
                    chk($sformatf("f%0d hit_x", e.idx), int'(bus.hit_x), e.x);
                    chk($sformatf("f%0d hit_y", e.idx), int'(bus.hit_y), e.y);
`endif
                end
            end else if (bus.hit_pulse) begin
                chk("hit_pulse outside frame_done", 1, 0);
            end
        end
    end

    initial begin
        //          a_pf fe_apf b_pf msk all3 ab fe_ab | apf bpf ab hp cnt cd  x   y
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,   0,  0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0,  0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,   0,  0};
        vecs[3]  = '{0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,   0,  0};
        vecs[4]  = '{0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0,  0};
        vecs[5]  = '{0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 1, 1, 1,  90, 20};
        vecs[6]  = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 1, 120, 40};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 120, 40};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 2, 1, 200, 70};
        vecs[9]  = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 2, 1, 120, 40};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 2, 0, 120, 40};
        vecs[11] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 3, 1, 120, 40};
        vecs[12] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 3, 1, 120, 40};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0, 120, 40};
        vecs[14] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 3, 1, 120, 40};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 1, 120, 40};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0, 120, 40};
        vecs[17] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 3, 1, 120, 40};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 1, 120, 40};

        reset          = 1'b1;
        bus.display_on = 1'b0;
        bus.vsync      = 1'b0;
        bus.hpos       = '0;
        bus.vpos       = '0;
        bus.gfx_a      = 1'b0;
        bus.gfx_b      = 1'b0;
        bus.playfield  = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_frame(vecs[i], i);
        end

        // Mid-frame reset with overlapping tanks, released while vsync is high.
        drive(1, 1, 1, 1, 120, 40, 0);
        drive(1, 1, 1, 0, 121, 40, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.display_on = 1'b0;
        bus.gfx_a      = 1'b0;
        bus.gfx_b      = 1'b0;
        bus.playfield  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        chk_all_zero("after release");
        run_frame('{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0,  0}, 100);
        run_frame('{0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 1, 1, 120, 40}, 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_collision_unit.md
Name: sprite_collision_unit

Overview:
- Sits downstream of the two tank sprite renderers and the playfield generator; consumes the per-pixel gfx bits they produce.
- Accumulates per-frame collision flags: tank A vs playfield, tank B vs playfield, tank A vs tank B.
- Publishes the flags as stable registers once per frame at the vsync rising edge.
- Maintains a saturating A-vs-B hit counter with a frame-based cooldown so that one contact scores once.

Parameters:
- HIT_W, 8, width of hit_count.
- COOLDOWN_FRAMES, 30, frames after a scored hit during which further A-B contact is not scored (1..255).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- display_on  in  1  visible-area qualifier; pixels are ignored when low
- vsync  in  1  vertical sync from hvsync generator (level)
- hpos  in  10  current pixel x
- vpos  in  10  current pixel y
- gfx_a  in  1  tank A sprite pixel
- gfx_b  in  1  tank B sprite pixel
- playfield  in  1  playfield pixel
- coll_a_pf  out  1  tank A touched playfield in last completed frame
- coll_b_pf  out  1  tank B touched playfield in last completed frame
- coll_ab  out  1  tanks overlapped in last completed frame
- frame_done  out  1  one-cycle pulse when the coll_* outputs update
- hit_pulse  out  1  one-cycle pulse, coincident with frame_done, when a hit is scored
- hit_count  out  HIT_W  saturating count of scored hits
- cooldown_active  out  1  high while the scorer is in COOLDOWN

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; accumulators 0; vsync_d 0; scorer state IDLE; cooldown counter 0. Reset asserted mid-frame discards the partial frame.
- Pixel qualifier is pix_ok = display_on. Each cycle with pix_ok:
  - acc_a_pf |= gfx_a & playfield
  - acc_b_pf |= gfx_b & playfield
  - acc_ab |= gfx_a & gfx_b
- Frame end: fe = vsync & ~vsync_d, with vsync_d registered every cycle. A vsync held high for many cycles gives exactly one fe. vsync high during reset release does not produce fe.
- On the fe cycle, registered with latency 1 (outputs valid the cycle after fe):
  - coll_* are loaded from the accumulators, including any pixel hit qualified on the fe cycle itself.
  - The accumulators are cleared.
  - frame_done pulses for 1 cycle.
- coll_* hold their values between frame_done pulses.
- Scorer FSM, evaluated only on fe, using the accumulator value ab_now (acc_ab OR the current-cycle hit):
  - IDLE: if ab_now, go to COOLDOWN, assert hit_pulse, increment hit_count (saturating at all-ones), and load cdn = COOLDOWN_FRAMES. Otherwise stay in IDLE.
  - COOLDOWN: cdn decrements on each fe. When cdn reaches 0 on an fe, go to IDLE on that fe. That frame's ab_now is not scored.
  - The next possible hit is therefore COOLDOWN_FRAMES+1 frames after the scored one.
- cooldown_active = (state == COOLDOWN).
- hit_count at saturation: stays all-ones. hit_pulse still pulses.
- Simultaneous gfx_a, gfx_b and playfield in one pixel: all three flags are set.
- Widths: hpos and vpos are only used by the optional feature. cdn is 8 bits.

Optional Feature:
- Macro: SPRITE_COLLISION_COORD_EN.
- When defined, the block adds the outputs hit_x[9:0] and hit_y[9:0]:
  - Holds the hpos/vpos of the first qualified gfx_a & gfx_b pixel of the frame (first in raster order).
  - Published on frame_done alongside coll_ab.
  - Holds the previous value if the frame had no A-B overlap.
  - Reset value 0.
- When undefined, these ports and their registers do not exist, and hpos/vpos are unused.

Test Plan:
- Reset asserted mid-frame with gfx_a = gfx_b = 1, then released -> all outputs 0 immediately; first frame_done follows the first vsync rising edge.
- One frame with gfx_a & playfield at a single pixel (hpos=100, vpos=50) -> after the next vsync edge: coll_a_pf=1, coll_b_pf=0, coll_ab=0, frame_done pulses 1 cycle. Following empty frame -> coll_a_pf returns to 0.
- gfx_a & gfx_b overlap for 5 consecutive frames, COOLDOWN_FRAMES=2 -> hit_pulse on frames 1 and 4 only; hit_count=2; cooldown_active high for frames 1-3.
- Pixel hit applied exactly on the vsync rising-edge cycle with display_on=1 -> counted in the frame being closed, and the accumulators are cleared for the next frame.
- HIT_W=2, 5 separated hits -> hit_count reads 1,2,3,3,3; hit_pulse occurs 5 times.
- SPRITE_COLLISION_COORD_EN defined, overlaps at (120,40) and (130,60) in one frame -> hit_x=120, hit_y=40. Next frame has no overlap -> hit_x=120, hit_y=40 are held.
